// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the fixed-priority interrupt controller.
// Lower source index means higher priority.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam int          N_SRC_DEF    = 8;
    localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0018;
    localparam logic [31:0] VEC_STRIDE   = 32'd4;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins.
// Used for both request selection and in-service selection.
module int_prio_enc #(
    parameter  int N   = 8,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   vec_i,
    output logic           valid_o,
    output logic [IDW-1:0] idx_o
);

    // scan from the top so the lowest set index is left in idx_o
    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDW'(i);
        end
    end

endmodule

// File: rtl/int_prio_ctrl.sv
// Edge-latched fixed-priority interrupt controller with IDLE/REQ/SERVICE FSM.
// Define INT_NEST_EN to let higher-priority sources preempt during SERVICE.
module int_prio_ctrl
    import int_ctrl_pkg::*;
#(
    parameter  int          N_SRC    = N_SRC_DEF,
    parameter  logic [31:0] VEC_BASE = VEC_BASE_DEF,
    localparam int          IDW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             INTA_irq,
    input  logic             eoi,
    output logic             INT_irq,
    output logic [IDW-1:0]   irq_id,
    output logic [31:0]      irq_vector,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service
);

    state_e state_q, state_d;

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] isv_q, isv_d;
    logic             inta_q;
    logic             int_q, int_d;
    logic [IDW-1:0]   id_q, id_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pm;
    logic [N_SRC-1:0] ack_bit;
    logic [N_SRC-1:0] top_bit;
    logic             inta_rise;
    logic             req_vld;
    logic             is_vld;
    logic [IDW-1:0]   req_idx;
    logic [IDW-1:0]   is_idx;
    logic             pop;
    logic             last;
    logic             req_ok;
    logic             nest_req;
    logic             ack;

    assign rise      = irq_src & ~src_q;
    assign pm        = pend_q & mask_q;
    assign inta_rise = INTA_irq & ~inta_q;
    assign mask_d    = mask_we ? mask_wdata : mask_q;
    assign ack_bit   = N_SRC'(1) << id_q;
    assign top_bit   = N_SRC'(1) << is_idx;
    assign pop       = eoi & is_vld;
    assign last      = !is_vld || (pop && ((isv_q & ~top_bit) == '0));

    int_prio_enc #(.N(N_SRC)) u_req_enc (
        .vec_i   (pm),
        .valid_o (req_vld),
        .idx_o   (req_idx)
    );

    int_prio_enc #(.N(N_SRC)) u_isv_enc (
        .vec_i   (isv_q),
        .valid_o (is_vld),
        .idx_o   (is_idx)
    );

`ifdef INT_NEST_EN
    assign nest_req = req_vld & is_vld & (req_idx < is_idx);
`else
    assign nest_req = 1'b0;
`endif

    // with something in service only a preempting source keeps REQ alive
    assign req_ok = is_vld ? nest_req : req_vld;

    // next-state, id selection and acknowledge/eoi bookkeeping
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_vld) begin
                    state_d = REQ;
                    id_d    = req_idx;
                end
            end
            REQ: begin
                if (inta_rise) begin
                    ack     = 1'b1;
                    state_d = SERVICE;
                end else if (req_ok) begin
                    id_d = req_idx;
                end else if (is_vld) begin
                    state_d = SERVICE;
                    id_d    = is_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (last) begin
                    if (req_vld) begin
                        state_d = REQ;
                        id_d    = req_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (nest_req) begin
                    state_d = REQ;
                    id_d    = req_idx;
                end else begin
                    id_d = is_idx;
                end
            end
            default: state_d = IDLE;
        endcase
        int_d  = (state_d == REQ);
        pend_d = (pend_q & ~(ack ? ack_bit : '0)) | rise;
        isv_d  = (isv_q & ~(pop ? top_bit : '0)) | (ack ? ack_bit : '0);
    end

    // state and sample registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            isv_q   <= '0;
            inta_q  <= 1'b0;
            int_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= irq_src;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            isv_q   <= isv_d;
            inta_q  <= INTA_irq;
            int_q   <= int_d;
            id_q    <= id_d;
        end
    end

    assign INT_irq    = int_q;
    assign irq_id     = id_q;
    assign irq_vector = VEC_BASE + VEC_STRIDE * 32'(id_q);
    assign pending    = pend_q;
    assign in_service = isv_q;

endmodule

// File: doc/int_prio_ctrl.md
INT_PRIO_CTRL -- requirements
Module: int_prio_ctrl

Interface
REQ-001 The block SHALL provide parameter N_SRC, default 8, number of interrupt sources (lower index = higher priority).
REQ-002 The block SHALL provide parameter VEC_BASE, default 32'h0000_0018, base address of the vector table (4 bytes per source).
REQ-003 The block SHALL provide port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit, asynchronous, active-high reset.
REQ-005 The block SHALL provide port irq_src, input, N_SRC bits, per-source request; rising edges are latched.
REQ-006 The block SHALL provide ports mask_we (input, 1 bit) and mask_wdata (input, N_SRC bits); a mask bit set to 1 enables its source.
REQ-007 The block SHALL provide port INTA_irq, input, 1 bit, CPU acknowledge; only its rising edge counts as an acknowledge.
REQ-008 The block SHALL provide port eoi, input, 1 bit, one-cycle end-of-interrupt pulse from the CPU return sequence.
REQ-009 The block SHALL provide port INT_irq, output, 1 bit, registered interrupt request to the CPU controller.
REQ-010 The block SHALL provide ports irq_id (output, clog2(N_SRC) bits) and irq_vector (output, 32 bits, VEC_BASE + 4*irq_id).
REQ-011 The block SHALL provide ports pending and in_service, both outputs of N_SRC bits, for status.

Function
REQ-012 At each clk edge, a pending bit SHALL be set where irq_src=1 and the previous sample was 0; a repeated edge on an already-pending source SHALL be absorbed without counting.
REQ-013 The state machine SHALL have three states, IDLE, REQ and SERVICE, with INT_irq=1 only in REQ.
REQ-014 IDLE->REQ SHALL occur at the first edge where (pending & mask) is nonzero; INT_irq and irq_id SHALL be valid one cycle after the pending bit is set.
REQ-015 In REQ, irq_id SHALL track the highest-priority pending & mask source every cycle, so a higher-priority arrival before acknowledge replaces it.
REQ-016 In REQ, if pending & mask becomes zero through a mask write, the block SHALL return to IDLE and drop INT_irq on the same edge.
REQ-017 An INTA_irq rising edge in REQ SHALL clear pending[irq_id], set in_service[irq_id], freeze irq_id/irq_vector, and move to SERVICE.
REQ-018 An INTA_irq rising edge in IDLE or SERVICE SHALL be ignored.
REQ-019 eoi in SERVICE SHALL clear the highest-priority in_service bit; when in_service becomes zero, the block SHALL go to IDLE, or go directly to REQ if pending & mask is nonzero.
REQ-020 eoi with in_service zero SHALL be ignored.
REQ-021 A new edge and an acknowledge in the same cycle SHALL both take effect: the acknowledged bit clears and a new edge on another source sets its pending bit.
REQ-022 A new edge on the acknowledged source in the same cycle SHALL leave that source pending.
REQ-023 A mask write SHALL take effect on the next edge and SHALL NOT alter pending or in_service.

Reset
REQ-024 rst SHALL force state=IDLE, INT_irq=0, irq_id=0, irq_vector=VEC_BASE, pending=0, in_service=0, mask=0, edge-sample registers=0 and INTA_irq-sample register=0.
REQ-025 rst asserted mid-REQ or mid-SERVICE SHALL discard all pending and in-service requests with no acknowledge side effects.

Configuration
REQ-026 With macro INT_NEST_EN defined, in SERVICE, a pending & mask source of higher priority than the highest in_service bit SHALL raise INT_irq; its acknowledge SHALL add an in_service bit (nesting), and eoi SHALL pop the highest-priority bit and then re-expose the older id.
REQ-027 Without INT_NEST_EN, INT_irq SHALL stay 0 throughout SERVICE and in_service SHALL hold at most one bit.

Structure
REQ-028 Package int_ctrl_pkg SHALL hold the state enum, default N_SRC, default VEC_BASE and the vector stride constant (4).
REQ-029 The fixed-priority encoder SHALL be sub-module int_prio_enc (N_SRC-bit vector in, valid plus index out), instantiated for both request selection and in-service selection.

Verification
REQ-030 Scenario: mask=8'hFF, irq_src[3] rises -> pending=8'h08 next edge, then INT_irq=1, irq_id=3, irq_vector=32'h24.
REQ-031 Scenario: src 5 and then src 1 rise before acknowledge -> irq_id changes 5->1; acknowledge leaves pending=8'h20 and in_service=8'h02; eoi -> REQ with irq_id=5.
REQ-032 Scenario: mask=8'h00 with src 2 rising -> INT_irq stays 0; a mask write of 8'h04 -> INT_irq=1 on the second edge; a mask write back to 0 in REQ -> IDLE.
REQ-033 Scenario: INTA_irq held high for 10 cycles -> exactly one acknowledge; eoi in IDLE -> no change.
REQ-034 Scenario (INT_NEST_EN): src 4 is in service and src 0 rises -> INT_irq=1, id 0; after acknowledge, in_service=8'h11; first eoi leaves 8'h10; without the macro, INT_irq stays 0 until eoi.
REQ-035 Scenario: rst pulsed in SERVICE -> all outputs at reset values; a later src edge is served normally.
